// File: rtl/diag_parity_encoder_pipe.sv
// rtl/diag_parity_encoder_pipe.sv - pipelined 16->34 diagonal/parity encoder, LANES words per beat
module diag_parity_encoder_pipe #(
  parameter int LANES = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_bypass,
  input  logic                  cfg_inj_en,
  input  logic [2:0]            cfg_inj_lane,
  input  logic [5:0]            cfg_inj_bit,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*LANES-1:0]   in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [34*LANES-1:0]   out_data,
  output logic                  out_last,
  output logic [CNT_W-1:0]      out_frame_cnt,
  output logic                  busy
);

  function automatic logic [17:0] calc_check(input logic [15:0] x);
    logic [4:1] a, b, c, d, p;
    logic [6:1] dg;
    for (int k = 1; k <= 4; k++) begin
      a[k] = x[4-k];
      b[k] = x[8-k];
      c[k] = x[12-k];
      d[k] = x[16-k];
      p[k] = a[k] ^ b[k] ^ c[k] ^ d[k];
    end
    dg[1] = a[1] ^ b[2] ^ c[1] ^ d[2];
    dg[2] = b[1] ^ a[2] ^ c[2] ^ d[1];
    dg[3] = a[3] ^ b[4] ^ c[3] ^ d[4];
    dg[4] = b[3] ^ a[4] ^ c[4] ^ d[3];
    dg[5] = a[2] ^ b[3] ^ c[2] ^ d[3];
    dg[6] = b[2] ^ a[3] ^ c[3] ^ d[2];
    return {dg[6], dg[5], dg[4], p[4], d[1] ^ d[3], d[2] ^ d[4],
            dg[3], p[3], c[1] ^ c[3], c[2] ^ c[4],
            dg[2], p[2], b[1] ^ b[3], b[2] ^ b[4],
            dg[1], p[1], a[1] ^ a[3], a[2] ^ a[4]};
  endfunction

  logic                    s1_valid;
  logic [LANES-1:0][15:0]  s1_word;
  logic [LANES-1:0][17:0]  s1_chk;
  logic                    s1_last;
  logic                    s1_bypass;
  logic                    s1_inj;
  logic [2:0]              s1_inj_lane;
  logic [5:0]              s1_inj_bit;

  logic                    s1_adv, s2_adv, accept;
  logic                    inj_en_q, inj_pending, inj_rise, take_inj;
  logic [34*LANES-1:0]     s2_next;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid && in_ready;
  assign busy     = s1_valid || out_valid;

  // A rising edge in the same cycle as an accepted beat injects into that beat.
  assign inj_rise = cfg_inj_en && !inj_en_q;
  assign take_inj = accept && (inj_pending || inj_rise);

  always_ff @(posedge clk) begin
    if (rst) begin
      inj_en_q    <= 1'b0;
      inj_pending <= 1'b0;
    end else begin
      inj_en_q <= cfg_inj_en;
      if (take_inj)
        inj_pending <= 1'b0;
      else if (inj_rise)
        inj_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_word     <= '0;
      s1_chk      <= '0;
      s1_last     <= 1'b0;
      s1_bypass   <= 1'b0;
      s1_inj      <= 1'b0;
      s1_inj_lane <= '0;
      s1_inj_bit  <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (accept) begin
        for (int n = 0; n < LANES; n++) begin
          s1_word[n] <= in_data[16*n +: 16];
          s1_chk[n]  <= calc_check(in_data[16*n +: 16]);
        end
        s1_last     <= in_last;
        s1_bypass   <= cfg_bypass;
        s1_inj      <= take_inj;
        s1_inj_lane <= cfg_inj_lane;
        s1_inj_bit  <= cfg_inj_bit;
      end
    end
  end

  // Shifting a 34-bit one by more than 33 yields zero, so out-of-range bits flip nothing.
  always_comb begin
    s2_next = '0;
    for (int n = 0; n < LANES; n++) begin
      s2_next[34*n +: 34] = {(s1_bypass ? 18'd0 : s1_chk[n]), s1_word[n]};
      if (s1_inj && (s1_inj_lane == 3'(n)))
        s2_next[34*n +: 34] = s2_next[34*n +: 34] ^ (34'd1 << s1_inj_bit);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= s2_next;
        out_last <= s1_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      out_frame_cnt <= '0;
    else if (out_valid && out_ready && out_last)
      out_frame_cnt <= out_frame_cnt + 1'b1;
  end

endmodule

// File: tb/tb_diag_parity_encoder_pipe.sv
// tb/tb_diag_parity_encoder_pipe.sv - table-driven and sequence bench for diag_parity_encoder_pipe
module tb_diag_parity_encoder_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_bypass, cfg_inj_en;
  logic [2:0]  cfg_inj_lane;
  logic [5:0]  cfg_inj_bit;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_last, busy;
  logic [67:0] out_data;
  logic [3:0]  out_frame_cnt;

  diag_parity_encoder_pipe #(.LANES(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .cfg_bypass(cfg_bypass), .cfg_inj_en(cfg_inj_en),
    .cfg_inj_lane(cfg_inj_lane), .cfg_inj_bit(cfg_inj_bit),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_frame_cnt(out_frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] w0, w1;
    logic        byp;
    logic [33:0] e0, e1;
  } vec_t;

  typedef struct {
    logic [67:0] data;
    logic        last;
  } beat_t;

  vec_t        tab [6];
  beat_t       expq [$];
  int          nvec = 0;
  int          nerr = 0;
  logic        use_hand = 1'b0;
  logic [67:0] hand_exp = '0;
  logic        m_pend, m_en_q, hold_v, hold_l;
  logic [3:0]  m_cnt;
  logic [67:0] hold_d;

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [33:0] enc(input logic [15:0] x, input logic byp);
    logic [1:4] a, b, c, d;
    logic [17:0] ck;
    for (int k = 1; k <= 4; k++) begin
      a[k] = x[4-k]; b[k] = x[8-k]; c[k] = x[12-k]; d[k] = x[16-k];
    end
    ck[0]  = a[2] ^ a[4];                 ck[1]  = a[1] ^ a[3];
    ck[2]  = a[1] ^ b[1] ^ c[1] ^ d[1];   ck[3]  = a[1] ^ b[2] ^ c[1] ^ d[2];
    ck[4]  = b[2] ^ b[4];                 ck[5]  = b[1] ^ b[3];
    ck[6]  = a[2] ^ b[2] ^ c[2] ^ d[2];   ck[7]  = b[1] ^ a[2] ^ c[2] ^ d[1];
    ck[8]  = c[2] ^ c[4];                 ck[9]  = c[1] ^ c[3];
    ck[10] = a[3] ^ b[3] ^ c[3] ^ d[3];   ck[11] = a[3] ^ b[4] ^ c[3] ^ d[4];
    ck[12] = d[2] ^ d[4];                 ck[13] = d[1] ^ d[3];
    ck[14] = a[4] ^ b[4] ^ c[4] ^ d[4];   ck[15] = b[3] ^ a[4] ^ c[4] ^ d[3];
    ck[16] = a[2] ^ b[3] ^ c[2] ^ d[3];   ck[17] = b[2] ^ a[3] ^ c[3] ^ d[2];
    return {(byp ? 18'd0 : ck), x};
  endfunction

  // Reference pipeline: expected beats queued at acceptance, checked at output transfer.
  task automatic monitor();
    beat_t       b;
    logic [67:0] e;
    logic        rise;
    int          ln, bt;
    forever begin
      @(negedge clk);
      if (rst) begin
        expq.delete();
        m_pend = 1'b0; m_en_q = 1'b0; m_cnt = '0; hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          chk("stall_valid", 68'(out_valid), 68'd1);
          chk("stall_data", out_data, hold_d);
          chk("stall_last", 68'(out_last), 68'(hold_l));
        end
        hold_v = out_valid && !out_ready;
        hold_d = out_data;
        hold_l = out_last;
        if (out_valid && out_ready) begin
          if (expq.size() == 0) begin
            chk("spurious_beat", 68'(out_valid), 68'd0);
          end else begin
            b = expq.pop_front();
            chk("data", out_data, b.data);
            chk("last", 68'(out_last), 68'(b.last));
            chk("frame_cnt_run", 68'(out_frame_cnt), 68'(m_cnt));
          end
          if (out_last) m_cnt = m_cnt + 4'd1;
        end
        rise = cfg_inj_en && !m_en_q;
        if (in_valid && in_ready) begin
          e = use_hand ? hand_exp : {enc(in_data[31:16], cfg_bypass), enc(in_data[15:0], cfg_bypass)};
          if (m_pend || rise) begin
            ln = int'(cfg_inj_lane);
            bt = int'(cfg_inj_bit);
            if (!use_hand && ln < 2 && bt < 34) e[34*ln + bt] = ~e[34*ln + bt];
            m_pend = 1'b0;
          end
          expq.push_back('{data: e, last: in_last});
        end else if (rise) begin
          m_pend = 1'b1;
        end
        m_en_q = cfg_inj_en;
      end
    end
  endtask

  task automatic send(input logic [31:0] d, input logic byp, input logic last,
                      input logic hand, input logic [67:0] he, input logic rnd_ready);
    logic acc;
    int   n = 0;
    in_valid = 1'b1; in_data = d; cfg_bypass = byp; in_last = last;
    use_hand = hand; hand_exp = he;
    do begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("accept_timeout", 68'(acc), 68'd1);
    in_valid = 1'b0; use_hand = 1'b0; cfg_inj_en = 1'b0;
  endtask

  task automatic drain(input logic rnd_ready);
    int n = 0;
    while ((busy || expq.size() != 0) && n < 500) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b1;
    chk("drain_busy", 68'(busy), 68'd0);
    chk("drain_pending", 68'(expq.size()), 68'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    tab[0] = '{16'h0001, 16'hFFFF, 1'b0, 34'h0C0010001, 34'h00000FFFF};
    tab[1] = '{16'h0002, 16'h0010, 1'b0, 34'h20C020002, 34'h048100010};
    tab[2] = '{16'h8000, 16'h0000, 1'b0, 34'h020848000, 34'h000000000};
    tab[3] = '{16'h0001, 16'h0002, 1'b1, 34'h000000001, 34'h000000002};
    tab[4] = '{16'h0010, 16'h8000, 1'b0, 34'h048100010, 34'h020848000};
    tab[5] = '{16'hFFFF, 16'h0001, 1'b1, 34'h00000FFFF, 34'h000000001};

    rst = 1'b1; cfg_bypass = 1'b0; cfg_inj_en = 1'b0; cfg_inj_lane = '0; cfg_inj_bit = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    fork monitor(); join_none
    do_reset();
    @(negedge clk);
    chk("rst_out_valid", 68'(out_valid), 68'd0);
    chk("rst_in_ready", 68'(in_ready), 68'd1);
    chk("rst_busy", 68'(busy), 68'd0);
    chk("rst_out_data", out_data, 68'd0);
    chk("rst_out_last", 68'(out_last), 68'd0);
    chk("rst_cnt", 68'(out_frame_cnt), 68'd0);

    // Table vectors back to back; bypass toggles per beat.
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = {tab[i].w1, tab[i].w0}; cfg_bypass = tab[i].byp;
      in_last = 1'b0; use_hand = 1'b1; hand_exp = {tab[i].e1, tab[i].e0};
      @(negedge clk);
      chk("tab_in_ready", 68'(in_ready), 68'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; use_hand = 1'b0;
    drain(1'b0);

    // Two-cycle latency.
    in_valid = 1'b1; in_data = {tab[0].w1, tab[0].w0}; cfg_bypass = 1'b0;
    use_hand = 1'b1; hand_exp = {tab[0].e1, tab[0].e0};
    @(posedge clk); #1;
    in_valid = 1'b0; use_hand = 1'b0;
    @(negedge clk);
    chk("lat_s1_valid", 68'(out_valid), 68'd0);
    chk("lat_s1_busy", 68'(busy), 68'd1);
    @(negedge clk);
    chk("lat_s2_valid", 68'(out_valid), 68'd1);
    chk("lat_s2_data", out_data, {tab[0].e1, tab[0].e0});
    drain(1'b0);

    // Random stream with random back-pressure.
    for (int i = 0; i < 64; i++)
      send($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, '0, 1'b1);
    drain(1'b1);

    // Injection: idle-cycle edge, then out-of-range bit, then coincident edge.
    cfg_inj_lane = 3'd1; cfg_inj_bit = 6'd20; cfg_inj_en = 1'b1;
    @(posedge clk); #1 cfg_inj_en = 1'b0;
    send(32'h0, 1'b0, 1'b0, 1'b1, {34'h000100000, 34'h0}, 1'b0);
    send(32'h0, 1'b0, 1'b0, 1'b1, 68'h0, 1'b0);
    cfg_inj_lane = 3'd0; cfg_inj_bit = 6'd40; cfg_inj_en = 1'b1;
    @(posedge clk); #1 cfg_inj_en = 1'b0;
    send(32'h0, 1'b0, 1'b0, 1'b1, 68'h0, 1'b0);
    cfg_inj_bit = 6'd0;
    send(32'h0, 1'b0, 1'b0, 1'b1, 68'h0, 1'b0);
    cfg_inj_lane = 3'd0; cfg_inj_bit = 6'd33; cfg_inj_en = 1'b1;
    send(32'h0000_0001, 1'b1, 1'b0, 1'b1, {34'h0, 34'h200000001}, 1'b0);
    send(32'h0000_0001, 1'b1, 1'b0, 1'b1, {34'h0, 34'h000000001}, 1'b0);
    drain(1'b0);

    // 17 frames of 3 beats on a 4-bit counter wrap to 1.
    do_reset();
    out_ready = 1'b1;
    for (int f = 0; f < 17; f++)
      for (int j = 0; j < 3; j++)
        send($urandom, 1'b0, (j == 2), 1'b0, '0, 1'b0);
    drain(1'b0);
    chk("frame_cnt_wrap", 68'(out_frame_cnt), 68'd1);

    // Reset with a full, stalled pipeline.
    out_ready = 1'b0;
    send(32'h1234_5678, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    send(32'h9ABC_DEF0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    chk("full_in_ready", 68'(in_ready), 68'd0);
    chk("full_busy", 68'(busy), 68'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 68'(out_valid), 68'd0);
    chk("mid_rst_busy", 68'(busy), 68'd0);
    chk("mid_rst_cnt", 68'(out_frame_cnt), 68'd0);
    chk("mid_rst_in_ready", 68'(in_ready), 68'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send({tab[1].w1, tab[1].w0}, 1'b0, 1'b0, 1'b1, {tab[1].e1, tab[1].e0}, 1'b0);
    drain(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
